// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Exports: INST_W, NOP_INSTR, RESET_PC_DEF, fetch_state_t, fetch_entry_t.
package fetch_unit_pkg;
   localparam int INST_W = 32;
   localparam logic [INST_W-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [INST_W-1:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic {
      RESET_WAIT,
      RUN
   } fetch_state_t;

   typedef struct packed {
      logic [INST_W-1:0] pc;
      logic [INST_W-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus: req/ready request, in-order rvalid response.
// master: req, addr out; ready, rvalid, rdata in. slave: the mirror.
interface fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ready;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req, addr,
      input  ready, rvalid, rdata
   );

   modport slave (
      input  req, addr,
      output ready, rvalid, rdata
   );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; push while full is honoured if popping.
// Ports: clk, rst_n, push/din, pop/dout(head), flush, full, empty, count.
module fetch_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, requests words, buffers and issues to decode.
// Ports: clk, reset_n, imem (bus master), jump_branch_enable/jump_target,
// stall, instruction, pc_out, inst_valid.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          DEPTH    = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   fetch_unit_if.master       imem,
   input  logic               jump_branch_enable,
   input  logic [31:0]        jump_target,
   input  logic               stall,
   output logic [INST_W-1:0]  instruction,
   output logic [31:0]        pc_out,
   output logic               inst_valid
);
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t state;
   fetch_state_t state_nxt;

   logic [31:0]   fetch_pc;
   logic [CW-1:0] discard_cnt;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] dq_count;
   logic [CW:0]   occupancy;
   logic          room;

   logic          aq_full;
   logic          aq_empty;
   logic [31:0]   aq_dout;
   logic          dq_full;
   logic          dq_empty;
   fetch_entry_t  dq_in;
   fetch_entry_t  dq_out;

   logic          redirect;
   logic          accept;
   logic          resp;
   logic          keep;
   logic          take;
   logic          use_fifo;
   logic          bypass;
   logic          idle;
   logic          dq_push;

   assign redirect  = jump_branch_enable;
   assign occupancy = {1'b0, outstanding} + {1'b0, dq_count};
   assign room      = occupancy < (CW+1)'(DEPTH);
   assign imem.addr = fetch_pc;

   assign accept = imem.req & imem.ready & ~aq_full;
   assign resp   = imem.rvalid & ~aq_empty;
   assign keep   = resp & (discard_cnt == '0) & ~redirect;

   // A fresh word goes straight to decode when nothing older is queued.
   assign take     = ~stall & ~redirect;
   assign use_fifo = take & ~dq_empty;
   assign bypass   = take & dq_empty & keep;
   assign idle     = take & ~use_fifo & ~bypass;
   assign dq_push  = keep & ~bypass & (~dq_full | use_fifo);

   assign dq_in.pc    = aq_dout;
   assign dq_in.instr = imem.rdata;

   always_comb begin
      state_nxt = state;
      imem.req  = 1'b0;
      unique case (state)
         RESET_WAIT: state_nxt = RUN;
         RUN:        imem.req  = room & ~redirect;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RESET_WAIT;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc <= RESET_PC;
      end else if (redirect) begin
         fetch_pc <= jump_target & ~32'h3;
      end else if (accept) begin
         fetch_pc <= fetch_pc + 32'd4;
      end
   end

   // Responses already in flight at a redirect belong to the old path.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         discard_cnt <= '0;
      end else if (redirect) begin
         discard_cnt <= outstanding - CW'(resp);
      end else if (resp && discard_cnt != '0) begin
         discard_cnt <= discard_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         instruction <= NOP_INSTR;
         pc_out      <= RESET_PC;
         inst_valid  <= 1'b0;
      end else begin
         unique case (1'b1)
            redirect, idle: begin
               instruction <= NOP_INSTR;
               inst_valid  <= 1'b0;
            end
            use_fifo: begin
               instruction <= dq_out.instr;
               pc_out      <= dq_out.pc;
               inst_valid  <= 1'b1;
            end
            bypass: begin
               instruction <= imem.rdata;
               pc_out      <= aq_dout;
               inst_valid  <= 1'b1;
            end
            default: begin
               instruction <= instruction;
            end
         endcase
      end
   end

   fetch_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_addr_q (
      .clk   (clk),
      .rst_n (reset_n),
      .push  (accept),
      .din   (fetch_pc),
      .pop   (resp),
      .flush (1'b0),
      .dout  (aq_dout),
      .full  (aq_full),
      .empty (aq_empty),
      .count (outstanding)
   );

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_data_q (
      .clk   (clk),
      .rst_n (reset_n),
      .push  (dq_push),
      .din   (dq_in),
      .pop   (use_fifo),
      .flush (redirect),
      .dout  (dq_out),
      .full  (dq_full),
      .empty (dq_empty),
      .count (dq_count)
   );
endmodule
